// File: rtl/spi_slave.sv
// SPI mode 1 (CPOL=0, CPHA=1) responder: oversampled SCK/SS/MOSI, one-deep tx holding
// register, received words strobed out on rx_data/rx_valid.
//
// state     | meaning
// WAIT_IDLE | after reset; waits for a settled, deasserted SS so no frame is joined mid-word
// IDLE      | SS high, MISO parked low
// SHIFT     | frame active: tx on rising SCK, rx on falling SCK
module spi_slave #(
  parameter int DATA_BITS   = 8,
  parameter bit LSBF        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCK,
  input  logic                 SS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 miso_oe,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_active,
  output logic [5:0]           word_count,
  output logic                 underrun,
  output logic                 frame_error
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync, fill;
  logic                   sck_d, sck_rise_q, sck_fall_q;
  logic                   sck_s, ss_s, mosi_s, sync_ok;

  logic [CW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   tx_shift, rx_shift, rx_next, hold;
  logic                   full;

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  // The SS reset value of 1 is not a real sample; fill marks when the chain holds live data.
  assign sync_ok = fill[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync   <= '0;
      ss_sync    <= '1;
      mosi_sync  <= '0;
      fill       <= '0;
      sck_d      <= 1'b0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], SCK};
      ss_sync    <= {ss_sync[SYNC_STAGES-2:0], SS};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
      sck_d      <= sck_s;
      sck_rise_q <= sck_s & ~sck_d;
      sck_fall_q <= ~sck_s & sck_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (sync_ok && ss_s) state_next = IDLE;
      IDLE:      if (!ss_s)           state_next = SHIFT;
      SHIFT:     if (ss_s)            state_next = IDLE;
      default:                        state_next = WAIT_IDLE;
    endcase
  end

  assign rx_next = LSBF ? {mosi_s, rx_shift[DATA_BITS-1:1]}
                        : {rx_shift[DATA_BITS-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold        <= '0;
      full        <= 1'b0;
      MISO        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      word_count  <= '0;
      underrun    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      frame_error <= 1'b0;

      // Accept and consume are exclusive: accept needs empty, consume needs full.
      if (tx_valid && !full) begin
        hold <= tx_data;
        full <= 1'b1;
      end

      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (!ss_s) begin
            bit_cnt    <= '0;
            word_count <= '0;
          end
        end
        SHIFT: begin
          if (ss_s) begin
            MISO    <= 1'b0;
            bit_cnt <= '0;
            if (bit_cnt != '0) frame_error <= 1'b1;
          end else begin
            if (sck_rise_q) begin
              if (bit_cnt == '0) begin
                if (full) begin
                  tx_shift <= hold;
                  full     <= 1'b0;
                  MISO     <= LSBF ? hold[0] : hold[DATA_BITS-1];
                end else begin
                  tx_shift <= '0;
                  MISO     <= 1'b0;
                  underrun <= 1'b1;
                end
              end else begin
                tx_shift <= LSBF ? (tx_shift >> 1) : (tx_shift << 1);
                MISO     <= LSBF ? tx_shift[1] : tx_shift[DATA_BITS-2];
              end
            end
            if (sck_fall_q) begin
              rx_shift <= rx_next;
              if (bit_cnt == CW'(DATA_BITS - 1)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                if (word_count != 6'd63) word_count <= word_count + 6'd1;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
        end
        default: MISO <= 1'b0;
      endcase
    end
  end

  assign tx_ready     = ~full;
  assign miso_oe      = (state == SHIFT);
  assign frame_active = (state == SHIFT) && !ss_s;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: an MSB-first and an LSB-first instance share one SPI master and
// one tx feeder; results are compared against table constants and a word-level model.
module tb_spi_slave;

  localparam int PH = 4;

  logic       clk = 1'b0;
  logic       reset, SCK, SS, MOSI, tx_valid;
  logic [7:0] tx_data;

  logic       miso_a, oe_a, rdy_a, rxv_a, fa_a, ur_a, fe_a;
  logic       miso_b, oe_b, rdy_b, rxv_b, fa_b, ur_b, fe_b;
  logic [7:0] rxd_a, rxd_b;
  logic [5:0] wc_a, wc_b;

  always #5 clk = ~clk;

  spi_slave #(.DATA_BITS(8), .LSBF(1'b0), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset(reset), .SCK(SCK), .SS(SS), .MOSI(MOSI),
    .MISO(miso_a), .miso_oe(oe_a), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_a), .rx_data(rxd_a), .rx_valid(rxv_a), .frame_active(fa_a),
    .word_count(wc_a), .underrun(ur_a), .frame_error(fe_a));

  spi_slave #(.DATA_BITS(8), .LSBF(1'b1), .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset(reset), .SCK(SCK), .SS(SS), .MOSI(MOSI),
    .MISO(miso_b), .miso_oe(oe_b), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_b), .rx_data(rxd_b), .rx_valid(rxv_b), .frame_active(fa_b),
    .word_count(wc_b), .underrun(ur_b), .frame_error(fe_b));

  int n_cmp = 0, n_fail = 0;

  logic [7:0] rxa_q[$], rxb_q[$], feed_q[$];
  int ura_cnt = 0, urb_cnt = 0, fea_cnt = 0, feb_cnt = 0;

  always @(negedge clk) begin
    if (rxv_a) rxa_q.push_back(rxd_a);
    if (rxv_b) rxb_q.push_back(rxd_b);
    if (ur_a)  ura_cnt <= ura_cnt + 1;
    if (ur_b)  urb_cnt <= urb_cnt + 1;
    if (fe_a)  fea_cnt <= fea_cnt + 1;
    if (fe_b)  feb_cnt <= feb_cnt + 1;
  end

  // tx feeder: presents the head of feed_q and pops it once the handshake edge has passed.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (feed_q.size() > 0) begin
        tx_data  = feed_q[0];
        tx_valid = 1'b1;
        if (rdy_a === 1'b1) begin
          @(posedge clk);
          void'(feed_q.pop_front());
        end
      end else begin
        tx_valid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // bits are sent in the order bits[7], bits[6], ...; MISO captured at each falling edge
  task automatic spi_bits(input int n, input logic [7:0] bits,
                          output logic [7:0] ma, output logic [7:0] mb);
    ma = 8'h00;
    mb = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      SCK  = 1'b1;
      MOSI = bits[7-i];
      repeat (PH) @(negedge clk);
      ma[7-i] = miso_a;
      mb[7-i] = miso_b;
      SCK = 1'b0;
      repeat (PH - 1) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input int nw,
                           input logic [7:0] mw[4], input logic [7:0] tw[4], input bit supply,
                           input logic [7:0] e_ra[4], input logic [7:0] e_rb[4],
                           input logic [7:0] e_ma[4], input logic [7:0] e_mb[4],
                           input int e_ur);
    logic [7:0] ma, mb;
    int ur0a, ur0b, fe0a, fe0b;
    rxa_q.delete();
    rxb_q.delete();
    ur0a = ura_cnt; ur0b = urb_cnt; fe0a = fea_cnt; fe0b = feb_cnt;
    if (supply) for (int k = 0; k < nw; k++) feed_q.push_back(tw[k]);
    repeat (4) @(negedge clk);
    SS = 1'b0;
    repeat (8) @(negedge clk);
    check($sformatf("%s frame_active", tag), {fa_a, fa_b, oe_a, oe_b}, 4'hF);
    for (int k = 0; k < nw; k++) begin
      spi_bits(8, mw[k], ma, mb);
      check($sformatf("%s miso_a%0d", tag, k), ma, e_ma[k]);
      check($sformatf("%s miso_b%0d", tag, k), mb, e_mb[k]);
    end
    repeat (4) @(negedge clk);
    SS = 1'b1;
    repeat (12) @(negedge clk);
    check($sformatf("%s feed_drained", tag), feed_q.size(), 0);
    feed_q.delete();
    check($sformatf("%s rx_count_a", tag), rxa_q.size(), nw);
    check($sformatf("%s rx_count_b", tag), rxb_q.size(), nw);
    for (int k = 0; k < nw; k++) begin
      if (k < rxa_q.size()) check($sformatf("%s rx_a%0d", tag, k), rxa_q[k], e_ra[k]);
      if (k < rxb_q.size()) check($sformatf("%s rx_b%0d", tag, k), rxb_q[k], e_rb[k]);
    end
    check($sformatf("%s underrun", tag), {ura_cnt - ur0a, urb_cnt - ur0b}, {e_ur, e_ur});
    check($sformatf("%s frame_error", tag), {fea_cnt - fe0a, feb_cnt - fe0b}, 64'd0);
    check($sformatf("%s word_count", tag), {wc_a, wc_b}, {nw[5:0], nw[5:0]});
    check($sformatf("%s idle_outputs", tag), {miso_a, miso_b, oe_a, oe_b, rdy_a, rdy_b}, 6'b000011);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mosi;
    bit         supply;
    logic [7:0] rxa, rxb, misoa, misob;
    int         ur;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [7:0] mw[4], tw[4], ra[4], rb[4], ea[4], eb[4];
    logic [7:0] ma, mb;
    int         nw, fe0a, fe0b, ur0a, ur0b;
    bit         sup;

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 8'h3C, 8'h3C, 8'hA5, 8'hA5, 0};
    vecs[1] = '{8'h00, 8'hFF, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1};
    vecs[2] = '{8'h01, 8'h01, 1'b1, 8'h01, 8'h80, 8'h01, 8'h80, 0};
    vecs[3] = '{8'h12, 8'hC4, 1'b1, 8'hC4, 8'h23, 8'h12, 8'h48, 0};
    vecs[4] = '{8'hF0, 8'h0F, 1'b1, 8'h0F, 8'hF0, 8'hF0, 8'h0F, 0};

    reset = 1'b1; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs_a", {miso_a, oe_a, rdy_a, rxv_a, fa_a, ur_a, fe_a, rxd_a, wc_a},
          {7'b0010000, 8'h00, 6'd0});
    check("reset outputs_b", {miso_b, oe_b, rdy_b, rxv_b, fa_b, ur_b, fe_b, rxd_b, wc_b},
          {7'b0010000, 8'h00, 6'd0});
    reset = 1'b0;
    repeat (6) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      mw = '{vecs[v].mosi, 8'h00, 8'h00, 8'h00};
      tw = '{vecs[v].tx, 8'h00, 8'h00, 8'h00};
      ra = '{vecs[v].rxa, 8'h00, 8'h00, 8'h00};
      rb = '{vecs[v].rxb, 8'h00, 8'h00, 8'h00};
      ea = '{vecs[v].misoa, 8'h00, 8'h00, 8'h00};
      eb = '{vecs[v].misob, 8'h00, 8'h00, 8'h00};
      run_frame($sformatf("vec%0d", v), 1, mw, tw, vecs[v].supply, ra, rb, ea, eb, vecs[v].ur);
    end

    mw = '{8'h11, 8'h22, 8'h33, 8'h44};
    tw = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    rb = '{8'h88, 8'h44, 8'hCC, 8'h22};
    eb = '{8'h03, 8'h83, 8'h43, 8'hC3};
    run_frame("four_word", 4, mw, tw, 1'b1, mw, rb, tw, eb, 0);

    // abort after 5 falling edges
    rxa_q.delete(); rxb_q.delete();
    fe0a = fea_cnt; fe0b = feb_cnt; ur0a = ura_cnt; ur0b = urb_cnt;
    feed_q.push_back(8'h77);
    repeat (4) @(negedge clk);
    SS = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(5, 8'hB0, ma, mb);
    repeat (4) @(negedge clk);
    SS = 1'b1;
    repeat (12) @(negedge clk);
    check("abort rx_count", rxa_q.size() + rxb_q.size(), 0);
    check("abort frame_error", {fea_cnt - fe0a, feb_cnt - fe0b}, {32'd1, 32'd1});
    check("abort underrun", {ura_cnt - ur0a, urb_cnt - ur0b}, 64'd0);
    check("abort word_count", {wc_a, wc_b}, 12'd0);
    mw = '{8'h5A, 8'h00, 8'h00, 8'h00};
    tw = '{8'h33, 8'h00, 8'h00, 8'h00};
    eb = '{8'hCC, 8'h00, 8'h00, 8'h00};
    run_frame("after_abort", 1, mw, tw, 1'b1, mw, mw, tw, eb, 0);

    // reset after 3 bits, SS held low for 5 more bits
    rxa_q.delete(); rxb_q.delete();
    fe0a = fea_cnt; fe0b = feb_cnt; ur0a = ura_cnt; ur0b = urb_cnt;
    feed_q.push_back(8'h55);
    repeat (4) @(negedge clk);
    SS = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(3, 8'hE0, ma, mb);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    spi_bits(5, 8'h1F, ma, mb);
    repeat (6) @(negedge clk);
    check("midreset miso_during", {ma, mb}, 16'h0000);
    check("midreset outputs_a", {miso_a, oe_a, rdy_a, rxv_a, fa_a, rxd_a, wc_a},
          {5'b00100, 8'h00, 6'd0});
    check("midreset outputs_b", {miso_b, oe_b, rdy_b, rxv_b, fa_b, rxd_b, wc_b},
          {5'b00100, 8'h00, 6'd0});
    check("midreset rx_count", rxa_q.size() + rxb_q.size(), 0);
    check("midreset pulses", {fea_cnt - fe0a, feb_cnt - fe0b, ura_cnt - ur0a, urb_cnt - ur0b},
          128'd0);
    SS = 1'b1;
    repeat (12) @(negedge clk);
    mw = '{8'h96, 8'h00, 8'h00, 8'h00};
    tw = '{8'hE1, 8'h00, 8'h00, 8'h00};
    rb = '{8'h69, 8'h00, 8'h00, 8'h00};
    eb = '{8'h87, 8'h00, 8'h00, 8'h00};
    run_frame("after_reset", 1, mw, tw, 1'b1, mw, rb, tw, eb, 0);

    // randomized frames against the word-level model
    for (int f = 0; f < 12; f++) begin
      nw  = $urandom_range(1, 4);
      sup = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 4; k++) begin
        mw[k] = 8'($urandom);
        tw[k] = 8'($urandom);
        rb[k] = rev8(mw[k]);
        ea[k] = sup ? tw[k] : 8'h00;
        eb[k] = sup ? rev8(tw[k]) : 8'h00;
      end
      run_frame($sformatf("rand%0d", f), nw, mw, tw, sup, mw, rb, ea, eb, sup ? 0 : nw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
